l2_cache_ctrl_nway: RTL and testbench

N-way set-associative write-back L2 cache controller, the parametrised successor of the fixed 2-way L2 control FSM. Sits between the L1/CPU-side request port and physical memory, driving the tag/valid/dirty/data array write-enables and the memory-side handshake. The datapath supplies per-way hit/valid/dirty and a PLRU victim. The controller latches the victim on a miss and holds it stable through write-back and fetch.

---
 rtl/l2_cache_ctrl_nway_if.sv | 46 ++++
 rtl/l2_cache_ctrl_nway.sv | 141 ++++++++++++++
 tb/tb_l2_cache_ctrl_nway.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_cache_ctrl_nway_if.sv
// Bundle between the L2 control FSM and its surroundings (CPU port, tag/data datapath, memory port).
// The master modport is the controller; the slave modport is the CPU/datapath/memory side.
interface l2_cache_ctrl_nway_if #(
  parameter int WAYS = 4
);
  localparam int WIDX = $clog2(WAYS);

  // Handshakes: a CPU request is valid while exactly one of mem_read/mem_write is high and is held
  // until the single-cycle mem_resp; pmem_read/pmem_write are held until the single-cycle pmem_resp.
  logic            mem_read;
  logic            mem_write;
  logic            mem_resp;
  logic [WAYS-1:0] hit;
  logic [WAYS-1:0] valid_in;
  logic [WAYS-1:0] dirty_in;
  logic [WIDX-1:0] lru_way;
  logic            load_lru;
  logic [WIDX-1:0] mru_way;
  logic [WAYS-1:0] load_tag;
  logic [WAYS-1:0] load_valid;
  logic [WAYS-1:0] load_dirty;
  logic [WAYS-1:0] load_data;
  logic            dirty_set;
  logic            data_in_sel;
  logic [WIDX-1:0] data_way_sel;
  logic            pmemaddr_sel;
  logic            pmem_read;
  logic            pmem_write;
  logic            pmem_resp;
  logic            multi_hit_err;
  logic [1:0]      state_dbg;

  modport master (
    input  mem_read, mem_write, hit, valid_in, dirty_in, lru_way, pmem_resp,
    output mem_resp, load_lru, mru_way, load_tag, load_valid, load_dirty, load_data,
           dirty_set, data_in_sel, data_way_sel, pmemaddr_sel, pmem_read, pmem_write,
           multi_hit_err, state_dbg
  );

  modport slave (
    output mem_read, mem_write, hit, valid_in, dirty_in, lru_way, pmem_resp,
    input  mem_resp, load_lru, mru_way, load_tag, load_valid, load_dirty, load_data,
           dirty_set, data_in_sel, data_way_sel, pmemaddr_sel, pmem_read, pmem_write,
           multi_hit_err, state_dbg
  );
endinterface

// File: rtl/l2_cache_ctrl_nway.sv
// N-way set-associative write-back L2 control FSM: PROCESS, WRITE_BACK, FETCH.
// Optional macro L2_INVALID_FIRST_EN: miss victim is the lowest invalid way when one exists.
module l2_cache_ctrl_nway #(
  parameter int WAYS = 4
) (
  input logic                  clk,
  input logic                  rst,
  l2_cache_ctrl_nway_if.master bus
);
  localparam int WIDX = $clog2(WAYS);

  typedef enum logic [1:0] {
    PROCESS    = 2'd0,
    WRITE_BACK = 2'd1,
    FETCH      = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDX-1:0] victim_q, victim_d;
  logic [WIDX-1:0] victim;
  logic [WIDX-1:0] hit_way;
  logic            multi_hit_q, multi_hit_d;
  logic            multi_hit;
  logic            seen;
  logic            req;
  logic            any_hit;
  logic            need_wb;
  logic [WAYS-1:0] hit_oh;
  logic [WAYS-1:0] victim_oh;

  assign req               = bus.mem_read ^ bus.mem_write;
  assign any_hit           = |bus.hit;
  assign hit_oh            = WAYS'(1) << hit_way;
  assign victim_oh         = WAYS'(1) << victim_q;
  assign bus.multi_hit_err = multi_hit_q;
  assign bus.state_dbg     = state_q;

  // Lowest-index hit wins; any further hit bit flags a tag-array inconsistency.
  always_comb begin
    hit_way   = '0;
    multi_hit = 1'b0;
    seen      = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (bus.hit[i]) begin
        if (seen) begin
          multi_hit = 1'b1;
        end else begin
          hit_way = WIDX'(i);
          seen    = 1'b1;
        end
      end
    end
  end

`ifdef L2_INVALID_FIRST_EN
  always_comb begin
    victim = bus.lru_way;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!bus.valid_in[i]) victim = WIDX'(i);
    end
  end
`else
  always_comb begin
    victim = bus.lru_way;
  end
`endif

  // An invalid victim holds nothing worth saving, whichever way it was picked.
  assign need_wb = bus.valid_in[victim] & bus.dirty_in[victim];

  always_comb begin
    state_d          = state_q;
    victim_d         = victim_q;
    multi_hit_d      = multi_hit_q;
    bus.mem_resp     = 1'b0;
    bus.load_lru     = 1'b0;
    bus.mru_way      = '0;
    bus.load_tag     = '0;
    bus.load_valid   = '0;
    bus.load_dirty   = '0;
    bus.load_data    = '0;
    bus.dirty_set    = 1'b0;
    bus.data_in_sel  = 1'b0;
    bus.data_way_sel = '0;
    bus.pmemaddr_sel = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    case (state_q)
      PROCESS: begin
        if (req) begin
          if (any_hit) begin
            bus.mem_resp     = 1'b1;
            bus.load_lru     = 1'b1;
            bus.mru_way      = hit_way;
            bus.data_way_sel = hit_way;
            if (bus.mem_write) begin
              bus.load_data = hit_oh;
              bus.load_dirty = hit_oh;
              bus.dirty_set = 1'b1;
            end
            if (multi_hit) multi_hit_d = 1'b1;
          end else begin
            victim_d = victim;
            state_d  = need_wb ? WRITE_BACK : FETCH;
          end
        end
      end
      WRITE_BACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmemaddr_sel = 1'b1;
        bus.data_way_sel = victim_q;
        if (bus.pmem_resp) state_d = FETCH;
      end
      FETCH: begin
        bus.pmem_read = 1'b1;
        // The line is installed clean; the replayed request then hits in PROCESS.
        if (bus.pmem_resp) begin
          bus.load_data   = victim_oh;
          bus.load_tag    = victim_oh;
          bus.load_valid  = victim_oh;
          bus.load_dirty  = victim_oh;
          bus.data_in_sel = 1'b1;
          state_d         = PROCESS;
        end
      end
      default: state_d = PROCESS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PROCESS;
      victim_q    <= '0;
      multi_hit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      multi_hit_q <= multi_hit_d;
    end
  end
endmodule

// File: tb/tb_l2_cache_ctrl_nway.sv
// Directed bench for l2_cache_ctrl_nway (WAYS=4): drivers push expected mem_resp, fill and
// write-back records, cycle-stamped, into queues that a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_l2_cache_ctrl_nway;
  localparam int WAYS      = 4;
  localparam int PMEM_WAIT = 3;
  localparam int RESP_W    = 41;
  localparam int FILL_W    = 37;
  localparam int WB_W      = 25;

  logic        clk = 1'b0;
  logic        rst;
  logic        force_resp;
  logic [31:0] cyc = '0;
  int          checks = 0;
  int          errors = 0;

  logic [RESP_W-1:0] exp_q[$];
  logic [FILL_W-1:0] fill_q[$];
  logic [WB_W-1:0]   wb_q[$];

  l2_cache_ctrl_nway_if #(.WAYS(WAYS)) bus ();
  l2_cache_ctrl_nway #(.WAYS(WAYS)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory model: resp on the (PMEM_WAIT+1)th request cycle ----------------
  initial begin
    int cnt;
    cnt = 0;
    bus.pmem_resp = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst || !(bus.pmem_read || bus.pmem_write)) cnt = 0;
      else cnt++;
      bus.pmem_resp = (cnt == PMEM_WAIT + 1) || force_resp;
      if (cnt == PMEM_WAIT + 1) cnt = 0;
    end
  end

  // ---------------- expected-record builders ----------------
  function automatic logic [RESP_W-1:0] resp_pkt(input logic [15:0] c, input logic [1:0] w,
                                                 input logic wr);
    logic [3:0] oh;
    oh = 4'b0001 << w;
    return {c, w, w, 1'b1, (wr ? oh : 4'b0), (wr ? oh : 4'b0), 4'b0, 4'b0, wr, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic logic [FILL_W-1:0] fill_pkt(input logic [15:0] c, input logic [1:0] w);
    logic [3:0] oh;
    oh = 4'b0001 << w;
    return {c, oh, oh, oh, oh, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  endfunction

  function automatic logic [WB_W-1:0] wb_pkt(input logic [15:0] c, input logic [1:0] w);
    return {c, w, 1'b1, 1'b1, 1'b0, 4'b0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_resp) begin
        if (exp_q.size() == 0) check("unexpected_mem_resp", 64'd1, 64'd0);
        else check("mem_resp_pkt", {cyc[15:0], bus.mru_way, bus.data_way_sel, bus.load_lru,
                                    bus.load_data, bus.load_dirty, bus.load_tag, bus.load_valid,
                                    bus.dirty_set, bus.data_in_sel, bus.pmem_read, bus.pmem_write},
                   exp_q.pop_front());
      end
      if (|bus.load_tag) begin
        if (fill_q.size() == 0) check("unexpected_fill", 64'd1, 64'd0);
        else check("fill_pkt", {cyc[15:0], bus.load_tag, bus.load_valid, bus.load_data,
                                bus.load_dirty, bus.dirty_set, bus.data_in_sel, bus.pmemaddr_sel,
                                bus.pmem_read, bus.mem_resp}, fill_q.pop_front());
      end
      if (bus.pmem_write && bus.pmem_resp) begin
        if (wb_q.size() == 0) check("unexpected_wb", 64'd1, 64'd0);
        else check("wb_pkt", {cyc[15:0], bus.data_way_sel, bus.pmemaddr_sel, bus.pmem_write,
                              bus.pmem_read, bus.load_data}, wb_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_hit(input logic wr, input logic [3:0] h, input logic [1:0] exp_way);
    bus.mem_read  = !wr;
    bus.mem_write = wr;
    bus.hit       = h;
    exp_q.push_back(resp_pkt(cyc[15:0], exp_way, wr));
    tick(1);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit       = '0;
  endtask

  // Miss timing with a 4-cycle memory: write-back cycles c+1..c+4 (resp at c+4),
  // fetch cycles follow for 4 more, replay hit one cycle after the fill.
  task automatic do_miss(input logic wr, input logic [1:0] lru, input logic [3:0] v,
                         input logic [3:0] d, input logic [1:0] vic, input logic wb,
                         input logic drop);
    logic [15:0] c;
    int          lim;
    c             = cyc[15:0];
    bus.mem_read  = !wr;
    bus.mem_write = wr;
    bus.hit       = '0;
    bus.valid_in  = v;
    bus.dirty_in  = d;
    bus.lru_way   = lru;
    if (wb) begin
      wb_q.push_back(wb_pkt(c + 16'd4, vic));
      fill_q.push_back(fill_pkt(c + 16'd8, vic));
      if (!drop) exp_q.push_back(resp_pkt(c + 16'd9, vic, wr));
      lim = 9;
    end else begin
      fill_q.push_back(fill_pkt(c + 16'd4, vic));
      if (!drop) exp_q.push_back(resp_pkt(c + 16'd5, vic, wr));
      lim = 5;
    end
    tick(1);
    bus.lru_way = lru + 2'd1;
    bus.hit     = 4'b0001 << vic;
    if (drop) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
    tick(lim);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit       = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst          = 1'b1;
    force_resp   = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit      = '0;
    bus.valid_in = 4'hF;
    bus.dirty_in = '0;
    bus.lru_way  = '0;
    tick(2);
    @(negedge clk);
    check("rst_state", bus.state_dbg, 2'd0);
    check("rst_multi_hit", bus.multi_hit_err, 1'b0);
    check("rst_pmem", {bus.pmem_read, bus.pmem_write, bus.mem_resp}, 3'b000);
    tick(1);
    rst = 1'b0;

    do_hit(1'b0, 4'b0100, 2'd2);
    do_hit(1'b1, 4'b0001, 2'd0);
    @(negedge clk);
    check("no_multi_hit", bus.multi_hit_err, 1'b0);
    tick(1);

    // Dirty victim 3; lru_way moves mid-miss but the latched victim must not.
    do_miss(1'b0, 2'd3, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
`ifdef L2_INVALID_FIRST_EN
    do_miss(1'b0, 2'd0, 4'b1011, 4'b1111, 2'd2, 1'b0, 1'b0);
`else
    do_miss(1'b0, 2'd0, 4'b1011, 4'b1111, 2'd0, 1'b1, 1'b0);
`endif
    do_miss(1'b0, 2'd0, 4'b1110, 4'b1111, 2'd0, 1'b0, 1'b0);
    do_miss(1'b1, 2'd1, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0);
    do_miss(1'b0, 2'd2, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b1);
    tick(2);

    // Stray pmem_resp while idle in PROCESS.
    force_resp = 1'b1;
    @(negedge clk);
    check("stray_resp_outputs", {bus.load_tag, bus.load_data, bus.mem_resp}, 9'd0);
    tick(1);
    force_resp = 1'b0;
    @(negedge clk);
    check("stray_resp_state", bus.state_dbg, 2'd0);
    tick(1);

    // Both request lines high is not a request.
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b1;
    bus.hit       = 4'b0001;
    @(negedge clk);
    check("both_high_hit", {bus.mem_resp, bus.load_lru, bus.load_data}, 6'd0);
    tick(1);
    bus.hit = '0;
    @(negedge clk);
    check("both_high_miss", {bus.state_dbg, bus.pmem_read, bus.pmem_write}, 4'd0);
    tick(1);
    @(negedge clk);
    check("both_high_state", bus.state_dbg, 2'd0);
    tick(1);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;

    do_hit(1'b0, 4'b0110, 2'd1);
    @(negedge clk);
    check("multi_hit_set", bus.multi_hit_err, 1'b1);
    tick(3);
    @(negedge clk);
    check("multi_hit_held", bus.multi_hit_err, 1'b1);
    tick(1);

    // Reset two cycles into FETCH abandons the miss.
    bus.mem_read = 1'b1;
    bus.valid_in = 4'hF;
    bus.dirty_in = '0;
    bus.lru_way  = 2'd1;
    tick(1);
    @(negedge clk);
    check("fetch_entered", {bus.state_dbg, bus.pmem_read}, {2'd2, 1'b1});
    tick(1);
    rst = 1'b1;
    tick(1);
    rst          = 1'b0;
    bus.mem_read = 1'b0;
    @(negedge clk);
    check("rst_fetch_state", bus.state_dbg, 2'd0);
    check("rst_fetch_pmem", {bus.pmem_read, bus.pmem_write}, 2'b00);
    check("rst_clears_multi_hit", bus.multi_hit_err, 1'b0);
    tick(1);
    do_hit(1'b0, 4'b0010, 2'd1);
    tick(4);

    check("exp_q_drained", exp_q.size(), 0);
    check("fill_q_drained", fill_q.size(), 0);
    check("wb_q_drained", wb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
